// File: rtl/sudoku_board_decode.sv
// Purpose: cell-serial digit stream to N x N one-hot board register, with digit-range and length error flags.
// Latency: completing cell accepted at edge t gives out_valid from t+1; one board per N*N+1 cycles at best.
// Backpressure: in_ready is low while a finished board waits for out_ready; nothing is accepted until it drains.
module sudoku_board_decode #(
    parameter int N  = 9,   // grid side and digit range, 2..16
    parameter int DW = 4    // digit width, 2**DW must exceed N
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DW-1:0]      in_digit,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*N*N-1:0]   out_board,
    output logic               out_err_digit,
    output logic               out_err_len
);

    localparam int              CELLS     = N * N;
    localparam int              IW        = $clog2(CELLS);
    localparam logic [IW-1:0]   LAST_IDX  = IW'(CELLS - 1);
    localparam logic [DW-1:0]   MAX_DIGIT = DW'(N);

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [N-1:0]  cell_dec;
    logic          accept;
    logic          at_end;
    logic          complete;

    // Handshake flags come straight from the state register, so no input reaches an output combinationally.
    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);

    assign accept   = in_valid && in_ready;
    assign at_end   = (idx == LAST_IDX);
    assign complete = at_end || in_last;

    // Digit to one-hot: 1..N set one bit; 0 and out-of-range digits leave the cell empty.
    always_comb begin
        cell_dec = '0;
        for (int k = 0; k < N; k++) begin
            if (in_digit == DW'(k + 1)) begin
                cell_dec[k] = 1'b1;
            end
        end
    end

    // Fill/drain state machine: writes one cell per accepted digit, parks the board in FULL until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= FILL;
            idx           <= '0;
            out_board     <= '0;
            out_err_digit <= 1'b0;
            out_err_len   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        out_board[int'(idx) * N +: N] <= cell_dec;
                        if (in_digit > MAX_DIGIT) begin
                            out_err_digit <= 1'b1;
                        end
                        if (complete) begin
                            state <= FULL;
                            idx   <= '0;
                            // Early in_last or a missing in_last on the final cell both mean a malformed board.
                            if (in_last != at_end) begin
                                out_err_len <= 1'b1;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state         <= FILL;
                        out_board     <= '0;
                        out_err_digit <= 1'b0;
                        out_err_len   <= 1'b0;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule
